// File: rtl/nco_sweep_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller: default widths and the
// sweep state encoding.
package nco_sweep_ctrl_pkg;

  localparam int DEF_CNT_BIT   = 32;
  localparam int DEF_DWELL_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/nco_sweep_ctrl_phase_acc.sv
// Phase accumulator driven by the current tuning word, with a registered
// half-scale compare that produces the divided clock-enable waveform.
module phase_acc
  import nco_sweep_ctrl_pkg::*;
#(
  parameter int CNT_BIT = DEF_CNT_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [CNT_BIT-1:0] tune_word,
  output logic               div_out
);

  localparam logic [CNT_BIT-1:0] HALF_SCALE = {1'b1, {(CNT_BIT-1){1'b0}}};

  logic [CNT_BIT-1:0] acc_q, acc_d;
  logic               div_q, div_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + tune_word;
    end
    // Compare against the value acc will hold, so div_q tracks acc_q in the same cycle.
    div_d = en && !clr && (acc_d > HALF_SCALE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      div_q <= div_d;
    end
  end

  // Masking by en keeps the output low on the first cycle after the sweep stops.
  assign div_out = div_q & en;

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller: steps a tuning word from start to stop with a
// per-word dwell and drives a phase accumulator while the sweep runs.
module nco_sweep_ctrl
  import nco_sweep_ctrl_pkg::*;
#(
  parameter int CNT_BIT   = DEF_CNT_BIT,
  parameter int DWELL_BIT = DEF_DWELL_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_BIT-1:0]   cfg_start,
  input  logic [CNT_BIT-1:0]   cfg_stop,
  input  logic [CNT_BIT-1:0]   cfg_step,
  input  logic [DWELL_BIT-1:0] cfg_dwell,
  input  logic                 cfg_down,
  input  logic                 abort,
  output logic [CNT_BIT-1:0]   tune_word,
  output logic                 word_stb,
  output logic                 busy,
  output logic                 done,
  output logic                 div_out
);

  localparam logic [DWELL_BIT-1:0] DWELL_ONE = {{(DWELL_BIT-1){1'b0}}, 1'b1};

  sweep_state_e         state_q, state_d;
  logic [CNT_BIT-1:0]   tune_q, tune_d;
  logic [CNT_BIT-1:0]   stop_q, stop_d;
  logic [CNT_BIT-1:0]   step_q, step_d;
  logic [DWELL_BIT-1:0] dwell_cfg_q, dwell_cfg_d;
  logic [DWELL_BIT-1:0] dwell_q, dwell_d;
  logic                 down_q, down_d;
  logic                 word_stb_q, word_stb_d;

  logic [CNT_BIT-1:0]   remain;
  logic [CNT_BIT-1:0]   next_word;
  logic                 at_end;
  logic                 accept;

  // A dwell of 0 behaves as 1, so the counter reload value never underflows.
  function automatic logic [DWELL_BIT-1:0] dwell_load(input logic [DWELL_BIT-1:0] d);
    return (d == '0) ? '0 : d - DWELL_ONE;
  endfunction

  // Distance to stop is only meaningful when not at_end, which is the only case it is used.
  always_comb begin
    remain    = down_q ? (tune_q - stop_q) : (stop_q - tune_q);
    at_end    = (step_q == '0) || (down_q ? (tune_q <= stop_q) : (tune_q >= stop_q));
    next_word = (remain <= step_q) ? stop_q
              : (down_q ? (tune_q - step_q) : (tune_q + step_q));
  end

  assign accept = (state_q == ST_IDLE) && cfg_valid;

  always_comb begin
    state_d     = state_q;
    tune_d      = tune_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_cfg_d = dwell_cfg_q;
    dwell_d     = dwell_q;
    down_d      = down_q;
    word_stb_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          tune_d      = cfg_start;
          stop_d      = cfg_stop;
          step_d      = cfg_step;
          dwell_cfg_d = cfg_dwell;
          down_d      = cfg_down;
          dwell_d     = dwell_load(cfg_dwell);
          word_stb_d  = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_ONE;
        end else if (at_end) begin
          state_d = ST_DONE;
        end else begin
          tune_d     = next_word;
          word_stb_d = 1'b1;
          dwell_d    = dwell_load(dwell_cfg_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tune_q      <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_cfg_q <= '0;
      dwell_q     <= '0;
      down_q      <= 1'b0;
      word_stb_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tune_q      <= tune_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_cfg_q <= dwell_cfg_d;
      dwell_q     <= dwell_d;
      down_q      <= down_d;
      word_stb_q  <= word_stb_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign tune_word = tune_q;
  assign word_stb  = word_stb_q;

  phase_acc #(
    .CNT_BIT (CNT_BIT)
  ) u_phase_acc (
    .clk       (clk),
    .rst       (rst),
    .en        (busy),
    .clr       (accept),
    .tune_word (tune_q),
    .div_out   (div_out)
  );

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: a table of sweeps plus hand-written
// abort, divider, reset and abort-with-config sequences.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_start = '0;
  logic [31:0] cfg_stop = '0;
  logic [31:0] cfg_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_down = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] tune_word;
  logic        word_stb;
  logic        busy;
  logic        done;
  logic        div_out;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] got_w [0:15];
  int got_n, busy_n, done_n;

  typedef struct packed {
    logic [31:0]      start;
    logic [31:0]      stop;
    logic [31:0]      step;
    logic [15:0]      dwell;
    logic             down;
    logic [7:0]       n;
    logic [3:0][31:0] w;
    logic [7:0]       busy_cyc;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [0:NV-1];

  nco_sweep_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .cfg_down  (cfg_down),
    .abort     (abort),
    .tune_word (tune_word),
    .word_stb  (word_stb),
    .busy      (busy),
    .done      (done),
    .div_out   (div_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] s, p, st, input logic [15:0] d,
                         input logic dn, input int n, input logic [31:0] w0, w1, w2, w3,
                         input int bc);
    vecs[i].start    = s;
    vecs[i].stop     = p;
    vecs[i].step     = st;
    vecs[i].dwell    = d;
    vecs[i].down     = dn;
    vecs[i].n        = 8'(n);
    vecs[i].w[0]     = w0;
    vecs[i].w[1]     = w1;
    vecs[i].w[2]     = w2;
    vecs[i].w[3]     = w3;
    vecs[i].busy_cyc = 8'(bc);
  endtask

  // Entered and left at a negedge; on return the transfer edge has just passed.
  task automatic start_cfg(input logic [31:0] s, p, st, input logic [15:0] d, input logic dn);
    int g = 0;
    while (!cfg_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ready_before_cfg", 64'(cfg_ready), 64'd1);
    cfg_start = s;
    cfg_stop  = p;
    cfg_step  = st;
    cfg_dwell = d;
    cfg_down  = dn;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Samples from the current negedge until the done pulse or a cycle budget runs out.
  task automatic run_sweep();
    got_n = 0;
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 300; c++) begin
      if (word_stb) begin
        if (got_n < 16) got_w[got_n] = tune_word;
        got_n++;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    set_vec(0, 32'd100, 32'd400, 32'd100, 16'd3, 1'b0, 4, 32'd100, 32'd200, 32'd300, 32'd400, 12);
    set_vec(1, 32'd0, 32'd250, 32'd100, 16'd1, 1'b0, 4, 32'd0, 32'd100, 32'd200, 32'd250, 4);
    set_vec(2, 32'd1000, 32'd700, 32'd200, 16'd0, 1'b1, 3, 32'd1000, 32'd800, 32'd700, 32'd0, 3);
    set_vec(3, 32'd500, 32'd400, 32'd50, 16'd2, 1'b0, 1, 32'd500, 32'd0, 32'd0, 32'd0, 2);
    set_vec(4, 32'd10, 32'd20, 32'd0, 16'd1, 1'b0, 1, 32'd10, 32'd0, 32'd0, 32'd0, 1);
    set_vec(5, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd1, 1'b0, 2,
            32'hFFFF_FF00, 32'hFFFF_FFFF, 32'd0, 32'd0, 2);
    set_vec(6, 32'd300, 32'd0, 32'd200, 16'd1, 1'b1, 3, 32'd300, 32'd100, 32'd0, 32'd0, 3);

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tune_word", 64'(tune_word), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_word_stb", 64'(word_stb), 64'd0);
    check("rst_div_out", 64'(div_out), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);

    // Table-driven sweeps
    for (int i = 0; i < NV; i++) begin
      start_cfg(vecs[i].start, vecs[i].stop, vecs[i].step, vecs[i].dwell, vecs[i].down);
      run_sweep();
      check($sformatf("v%0d_word_count", i), 64'(got_n), 64'(vecs[i].n));
      for (int j = 0; j < int'(vecs[i].n) && j < got_n; j++)
        check($sformatf("v%0d_word%0d", i, j), 64'(got_w[j]), 64'(vecs[i].w[j]));
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'(vecs[i].busy_cyc));
      check($sformatf("v%0d_done_seen", i), 64'(done_n), 64'd1);
      check($sformatf("v%0d_done_busy", i), 64'(busy), 64'd0);
      check($sformatf("v%0d_done_ready", i), 64'(cfg_ready), 64'd0);
      @(negedge clk);
      check($sformatf("v%0d_done_len", i), 64'(done), 64'd0);
      check($sformatf("v%0d_idle_ready", i), 64'(cfg_ready), 64'd1);
      check($sformatf("v%0d_hold_word", i), 64'(tune_word), 64'(vecs[i].w[vecs[i].n - 1]));
    end

    // Abort after the second word of the up sweep
    start_cfg(32'd100, 32'd400, 32'd100, 16'd3, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_second_word", 64'(tune_word), 64'd200);
    check("abort_second_stb", 64'(word_stb), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_tune_word", 64'(tune_word), 64'd200);
    check("abort_ready", 64'(cfg_ready), 64'd1);
    done_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) done_n++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(done_n), 64'd0);
    check("abort_hold_word", 64'(tune_word), 64'd200);

    // Divider: quarter-scale tuning word, div_out high when acc is at 0.75 scale
    start_cfg(32'h4000_0000, 32'h4000_0000, 32'd1, 16'd20, 1'b0);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("div_k%0d", k), 64'(div_out), 64'((k % 4) == 3));
      if (k % 5 == 0) check($sformatf("div_busy_k%0d", k), 64'(busy), 64'd1);
      @(negedge clk);
    end
    check("div_done", 64'(done), 64'd1);
    check("div_out_in_done", 64'(div_out), 64'd0);
    @(negedge clk);

    // Reset mid-sweep while a new configuration is held on the inputs
    start_cfg(32'd100, 32'd400, 32'd100, 16'd3, 1'b0);
    cfg_start = 32'd7;
    cfg_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("run_ready_low", 64'(cfg_ready), 64'd0);
    check("run_no_transfer", 64'(tune_word), 64'd200);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tune_word", 64'(tune_word), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_word_stb", 64'(word_stb), 64'd0);
    check("midrst_div_out", 64'(div_out), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("postrst_transfer_word", 64'(tune_word), 64'd7);
    check("postrst_transfer_busy", 64'(busy), 64'd1);
    cfg_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("postrst_abort_busy", 64'(busy), 64'd0);

    // Abort together with cfg_valid in IDLE still accepts the configuration
    abort = 1'b1;
    start_cfg(32'd50, 32'd60, 32'd10, 16'd1, 1'b0);
    abort = 1'b0;
    check("idle_abort_word", 64'(tune_word), 64'd50);
    check("idle_abort_busy", 64'(busy), 64'd1);
    run_sweep();
    check("idle_abort_words", 64'(got_n), 64'd2);
    check("idle_abort_last", 64'(got_w[1]), 64'd60);
    check("idle_abort_done", 64'(done_n), 64'd1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 Parameter CNT_BIT, default 32, width of the tuning word and the phase accumulator.
REQ-002 Parameter DWELL_BIT, default 16, width of the dwell counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 cfg_valid  input  1  sweep configuration offered.
REQ-006 cfg_ready  output  1  controller accepts configuration (high only in IDLE).
REQ-007 cfg_start, cfg_stop, cfg_step  input  CNT_BIT each  first tuning word, last tuning word, unsigned step magnitude.
REQ-008 cfg_dwell  input  DWELL_BIT  cycles each word is held; 0 is treated as 1.
REQ-009 cfg_down  input  1  0 = ascending sweep, 1 = descending sweep.
REQ-010 abort  input  1  terminate the running sweep.
REQ-011 tune_word  output  CNT_BIT  tuning word currently applied to the accumulator.
REQ-012 word_stb  output  1  one-cycle pulse when tune_word takes a new value.
REQ-013 busy  output  1  high while the sweep runs.
REQ-014 done  output  1  one-cycle pulse on normal sweep completion.
REQ-015 div_out  output  1  divided clock-enable waveform from the phase accumulator.

Function
REQ-016 States SHALL be IDLE, RUN and DONE.
REQ-017 Handshake: the transfer occurs on the edge where cfg_valid and cfg_ready are both high; on that edge all cfg_* fields SHALL be latched, tune_word SHALL become cfg_start, the accumulator SHALL clear to 0, word_stb SHALL pulse, and the state SHALL go to RUN.
REQ-018 In RUN, busy SHALL be 1; the dwell counter SHALL load max(dwell,1)-1 on each new word and decrement each cycle.
REQ-019 When the dwell counter is 0 and the direction is up, tune_word >= stop or step = 0 SHALL move the state to DONE; otherwise tune_word SHALL become min(tune_word+step, stop) (overflow-safe compare: if stop-tune_word <= step then stop), word_stb SHALL pulse, and the dwell SHALL reload.
REQ-020 Descending direction SHALL mirror REQ-019: finish on tune_word <= stop or step = 0; otherwise next = max(tune_word-step, stop) without underflow.
REQ-021 A start value already beyond stop in the sweep direction SHALL produce a single-word sweep: start is held for one dwell, then DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, busy=0 and cfg_ready=0, then return to IDLE.
REQ-023 abort in RUN SHALL move the state to IDLE on the next edge with no done pulse; tune_word SHALL hold its value.
REQ-024 abort in IDLE or DONE SHALL be ignored; abort together with cfg_valid in IDLE SHALL accept the configuration.
REQ-025 Accumulator: while busy, acc SHALL update as acc <= acc + tune_word, modulo 2^CNT_BIT; it SHALL hold when not busy.
REQ-026 div_out SHALL be registered and set to 1 when acc > 2^(CNT_BIT-1), else 0; it SHALL be 0 when not busy.
REQ-027 tune_word SHALL hold its last value after DONE or abort until the next accepted configuration.

Reset
REQ-028 On rst=0 at a clock edge: state SHALL be IDLE; tune_word, acc, the dwell counter, word_stb, done, busy and div_out SHALL be 0; cfg_ready SHALL be 1 after reset release.
REQ-029 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.

Structure
REQ-030 A shared package SHALL hold the state enumeration and the default CNT_BIT and DWELL_BIT constants.
REQ-031 The phase accumulator and div_out compare SHALL be the sub-module phase_acc (inputs clk, rst, en, clr, tune_word; output div_out); the sweep FSM SHALL stay in nco_sweep_ctrl.

Verification
REQ-032 Up sweep: start=100, stop=400, step=100, dwell=3 -> tune_word 100/200/300/400, 3 cycles each, 4 word_stb pulses, busy for 12 cycles, then one done pulse.
REQ-033 Saturation: start=0, stop=250, step=100, dwell=1 -> tune_word 0, 100, 200, 250, then done.
REQ-034 Down sweep and dwell=0: start=1000, stop=700, step=200, cfg_down=1, dwell=0 -> tune_word 1000, 800, 700, one cycle each, then done.
REQ-035 Abort after the second word of REQ-032 -> busy=0 next cycle, no done pulse, tune_word=200, cfg_ready=1.
REQ-036 Divider: start=stop=2^30, dwell=20 -> acc cycles 0.25/0.5/0.75/0 of full scale; div_out high 1 cycle of every 4; done after 20 cycles.
REQ-037 Reset mid-sweep and cfg_valid held during RUN -> all outputs return to reset values, and no transfer occurs until IDLE.
